// File: rtl/cpu_alu_pkg.sv
// rtl/cpu_alu_pkg.sv - shared ALU opcodes and tag defaults for the execute stage
package cpu_alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int TAG_W_DEF = 6;
  typedef logic [TAG_W_DEF-1:0] alu_tag_t;

endpackage

// File: rtl/pipe_adder_seg.sv
// rtl/pipe_adder_seg.sv - one SEG-bit ripple slice of the pipelined adder
module pipe_adder_seg #(
  parameter int SEG = 16
) (
  input  logic           cin,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  output logic [SEG-1:0] sum_seg,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] full;

  assign full    = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin};
  assign sum_seg = full[SEG-1:0];
  assign cout    = full[SEG];
  // The carry into the MSB is recovered from the MSB sum bit and its operands.
  assign cmsb    = a_seg[SEG-1] ^ b_seg[SEG-1] ^ full[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/sub unit, one carry segment per stage
module pipe_adder
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipe_adder: STAGES must be 1..8 and divide WIDTH");
  end

  logic [STAGES-1:0]            v_r;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0][WIDTH-1:0] a_r, b_r, sum_r;
  logic [STAGES-1:0]            c_r;
  logic [STAGES-1:0][TAG_W-1:0] tag_r;
  logic                         ovf_r;

  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_sum;
  logic [STAGES-1:0]            src_c, src_v;
  logic [STAGES-1:0][TAG_W-1:0] src_tag;
  logic [STAGES-1:0][SEG-1:0]   seg_sum;
  logic [STAGES-1:0]            seg_cout, seg_cmsb;

  // Remaining operands are kept right-aligned, so each slice reads the low SEG bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_a[k]   = in_a;
      assign src_b[k]   = (in_op == ALU_OP_SUB) ? ~in_b : in_b;
      assign src_sum[k] = '0;
      assign src_c[k]   = in_op;
      assign src_v[k]   = in_valid;
      assign src_tag[k] = in_tag;
    end else begin : g_body
      assign src_a[k]   = a_r[k-1];
      assign src_b[k]   = b_r[k-1];
      assign src_sum[k] = sum_r[k-1];
      assign src_c[k]   = c_r[k-1];
      assign src_v[k]   = v_r[k-1];
      assign src_tag[k] = tag_r[k-1];
    end

    pipe_adder_seg #(.SEG(SEG)) u_seg (
      .cin     (src_c[k]),
      .a_seg   (src_a[k][SEG-1:0]),
      .b_seg   (src_b[k][SEG-1:0]),
      .sum_seg (seg_sum[k]),
      .cout    (seg_cout[k]),
      .cmsb    (seg_cmsb[k])
    );
  end

  // A stage moves when it or any later stage has a hole, or the consumer takes the head.
  always_comb begin
    logic full_run;
    full_run = 1'b1;
    adv      = '0;
    for (int k = LAST; k >= 0; k--) begin
      full_run = full_run & v_r[k];
      adv[k]   = out_ready | ~full_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      c_r   <= '0;
      tag_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_r[k]                  <= src_v[k];
          a_r[k]                  <= src_a[k] >> SEG;
          b_r[k]                  <= src_b[k] >> SEG;
          sum_r[k]                <= src_sum[k];
          sum_r[k][k*SEG +: SEG]  <= seg_sum[k];
          c_r[k]                  <= seg_cout[k];
          tag_r[k]                <= src_tag[k];
        end
      end
      if (adv[LAST]) ovf_r <= seg_cmsb[LAST] ^ seg_cout[LAST];
      if (flush) v_r <= '0;
    end
  end

  logic unused_rem;
  assign unused_rem = ^{a_r[LAST], b_r[LAST]};

  assign in_ready  = adv[0];
  assign out_valid = v_r[LAST];
  assign out_sum   = sum_r[LAST];
  assign out_carry = c_r[LAST];
  assign out_ovf   = ovf_r;
  assign out_tag   = tag_r[LAST];

endmodule
